// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core.
// Contents:
//   DEF_DATA_W / DEF_REG_AW : default datapath and register-address widths
//   ALU_*                   : 4-bit ALU control codes
//   fwd_sel_e               : operand forwarding source select
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LSW = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b1011;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding multiplexer for one ALU source operand.
// Ports:
//   src_addr        : registered source register number of the EX instruction
//   reg_data        : registered register-file read data for that source
//   exmem_*         : write-back intent of the instruction in EX/MEM
//   memwb_*         : write-back intent of the instruction in MEM/WB
//   operand         : selected operand value
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] operand
);

  fwd_sel_e sel;

  // $0 is hardwired to zero, so a pending write to it must never be forwarded.
  // The younger EX/MEM result takes priority over MEM/WB.
  always_comb begin
    sel = FWD_REG;
    if (src_addr != '0) begin
      if (exmem_reg_write && (exmem_rd == src_addr)) begin
        sel = FWD_EXMEM;
      end else if (memwb_reg_write && (memwb_rd == src_addr)) begin
        sel = FWD_MEMWB;
      end
    end
  end

  always_comb begin
    case (sel)
      FWD_EXMEM: operand = exmem_result;
      FWD_MEMWB: operand = memwb_result;
      default:   operand = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand delivery.
// Captures decoded fields and register read data, extends the immediate,
// resolves EX/MEM and MEM/WB forwarding for rs and rt, and raises
// load_use_stall when the instruction in ID needs a load result still in EX.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   id_*                       : decoded instruction from ID
//   flush                      : kill the instruction entering EX
//   exmem_*, memwb_*           : downstream write-back info for forwarding
//   alu_in1, alu_in2, alu_ctrl : ALU operands and control
//   ex_*                       : EX-stage state passed to EX/MEM
//   load_use_stall             : hold PC/IF/ID this cycle
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm16,
  input  logic              id_zero_ext,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_ctrl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_stall
);

  logic              vld_p1;
  logic              reg_write_p1, mem_read_p1, mem_write_p1, alu_src_p1;
  logic [3:0]        alu_ctrl_p1;
  logic [REG_AW-1:0] dest_p1, rs_addr_p1, rt_addr_p1;
  logic [DATA_W-1:0] rs_data_p1, rt_data_p1, imm_p1;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              bubble;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm,
                                                input logic zero_ext);
    logic signed [DATA_W-1:0] sx;
    sx = {{(DATA_W-16){imm[15]}}, imm};
    return zero_ext ? {{(DATA_W-16){1'b0}}, imm} : sx;
  endfunction

  // Conservative: rt is compared even when the ID instruction uses an immediate.
  assign load_use_stall = vld_p1 & mem_read_p1 & id_valid & (dest_p1 != '0) &
                          ((dest_p1 == id_rs_addr) | (dest_p1 == id_rt_addr));

  // A flush and a stall together still produce a single bubble.
  assign bubble = flush | load_use_stall;

  // ---- ID -> EX stage register (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      alu_src_p1   <= 1'b0;
      alu_ctrl_p1  <= 4'b0000;
      dest_p1      <= '0;
      rs_addr_p1   <= '0;
      rt_addr_p1   <= '0;
      rs_data_p1   <= '0;
      rt_data_p1   <= '0;
      imm_p1       <= '0;
    end else begin
      vld_p1       <= id_valid;
      reg_write_p1 <= id_reg_write;
      mem_read_p1  <= id_mem_read;
      mem_write_p1 <= id_mem_write;
      alu_src_p1   <= id_alu_src;
      alu_ctrl_p1  <= id_alu_ctrl;
      dest_p1      <= id_reg_dst ? id_rd_addr : id_rt_addr;
      rs_addr_p1   <= id_rs_addr;
      rt_addr_p1   <= id_rt_addr;
      rs_data_p1   <= id_rs_data;
      rt_data_p1   <= id_rt_data;
      imm_p1       <= ext_imm(id_imm16, id_zero_ext);
    end
  end

  // ---- EX operand forwarding (combinational from p1) ----
  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_addr        (rs_addr_p1),
    .reg_data        (rs_data_p1),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .operand         (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_addr        (rt_addr_p1),
    .reg_data        (rt_data_p1),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .operand         (rt_fwd)
  );

  assign alu_in1       = rs_fwd;
  assign alu_in2       = alu_src_p1 ? imm_p1 : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_ctrl      = alu_ctrl_p1;
  assign ex_valid      = vld_p1;
  assign ex_dest       = dest_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic        zext, alu_src, reg_dst;
    logic [3:0]  ctrl;
    logic        regw, mr, mw;
  } id_t;

  typedef struct packed {
    id_t         id;
    logic        ew;
    logic [4:0]  erd;
    logic [31:0] eres;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic [31:0] e_in1, e_in2, e_st;
    logic [4:0]  e_dest;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  id_t         cur;
  logic        flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  id_t  m_ex;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[8];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(cur.valid), .id_rs_addr(cur.rs), .id_rt_addr(cur.rt), .id_rd_addr(cur.rd),
    .id_rs_data(cur.rsd), .id_rt_data(cur.rtd), .id_imm16(cur.imm),
    .id_zero_ext(cur.zext), .id_alu_src(cur.alu_src), .id_reg_dst(cur.reg_dst),
    .id_alu_ctrl(cur.ctrl), .id_reg_write(cur.regw), .id_mem_read(cur.mr),
    .id_mem_write(cur.mw), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .ex_valid(ex_valid),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
  );

  function automatic id_t mk_id(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd,
                                input logic [15:0] imm, input logic zext, src, rdst,
                                input logic [3:0] ctrl, input logic regw, mr, mw);
    id_t r;
    r.valid = 1'b1; r.rs = rs; r.rt = rt; r.rd = rd; r.rsd = rsd; r.rtd = rtd;
    r.imm = imm; r.zext = zext; r.alu_src = src; r.reg_dst = rdst; r.ctrl = ctrl;
    r.regw = regw; r.mr = mr; r.mw = mw;
    return r;
  endfunction

  function automatic vec_t mk_vec(input id_t id, input logic ew, input logic [4:0] erd,
                                  input logic [31:0] eres, input logic mw,
                                  input logic [4:0] mrd, input logic [31:0] mres,
                                  input logic [31:0] in1, in2, st, input logic [4:0] dest);
    vec_t v;
    v.id = id; v.ew = ew; v.erd = erd; v.eres = eres; v.mw = mw; v.mrd = mrd;
    v.mres = mres; v.e_in1 = in1; v.e_in2 = in2; v.e_st = st; v.e_dest = dest;
    return v;
  endfunction

  // Reference: value the EX instruction sees for a source register.
  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] regd);
    if (a == 0) return regd;
    if (exmem_reg_write && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd == a) return memwb_result;
    return regd;
  endfunction

  function automatic logic [31:0] m_imm(input logic [15:0] imm, input logic zext);
    int s;
    s = $signed(imm);
    return zext ? {16'h0000, imm} : s;
  endfunction

  function automatic logic m_stall();
    logic [4:0] d;
    d = m_ex.reg_dst ? m_ex.rd : m_ex.rt;
    return m_ex.valid && m_ex.mr && cur.valid && d != 0 && (d == cur.rs || d == cur.rt);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] e1, e2, es;
    logic [4:0]  ed;
    e1 = m_fwd(m_ex.rs, m_ex.rsd);
    es = m_fwd(m_ex.rt, m_ex.rtd);
    e2 = m_ex.alu_src ? m_imm(m_ex.imm, m_ex.zext) : es;
    ed = m_ex.reg_dst ? m_ex.rd : m_ex.rt;
    chk("m_valid", 32'(ex_valid), 32'(m_ex.valid));
    chk("m_regw", 32'(ex_reg_write), 32'(m_ex.regw));
    chk("m_mr", 32'(ex_mem_read), 32'(m_ex.mr));
    chk("m_mw", 32'(ex_mem_write), 32'(m_ex.mw));
    chk("m_ctrl", 32'(alu_ctrl), 32'(m_ex.ctrl));
    chk("m_dest", 32'(ex_dest), 32'(ed));
    chk("m_in1", alu_in1, e1);
    chk("m_in2", alu_in2, e2);
    chk("m_store", ex_store_data, es);
  endtask

  // Called at least 1 time unit after an edge with inputs already driven.
  task automatic cycle();
    logic st;
    #1;
    st = m_stall();
    chk("m_stall", 32'(load_use_stall), 32'(st));
    @(posedge clk);
    if (!rst_n || flush || st) m_ex = '0;
    else m_ex = cur;
    #1;
    check_model();
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, 32'(ex_valid), 0);
    chk({nm, "_regw"}, 32'(ex_reg_write), 0);
    chk({nm, "_mr"}, 32'(ex_mem_read), 0);
    chk({nm, "_mw"}, 32'(ex_mem_write), 0);
    chk({nm, "_stall"}, 32'(load_use_stall), 0);
    chk({nm, "_dest"}, 32'(ex_dest), 0);
    chk({nm, "_ctrl"}, 32'(alu_ctrl), 0);
    chk({nm, "_in1"}, alu_in1, 0);
    chk({nm, "_in2"}, alu_in2, 0);
    chk({nm, "_store"}, ex_store_data, 0);
  endtask

  initial begin
    // add $3,$1,$2
    tbl[0] = mk_vec(mk_id(1, 2, 3, 5, 7, 0, 0, 0, 1, ALU_ADD, 1, 0, 0),
                    0, 0, 0, 0, 0, 0, 32'd5, 32'd7, 32'd7, 5'd3);
    // both forwarders match rs: EX/MEM wins
    tbl[1] = mk_vec(mk_id(1, 2, 3, 5, 7, 0, 0, 0, 1, ALU_ADD, 1, 0, 0),
                    1, 1, 32'h10, 1, 1, 32'h20, 32'h10, 32'd7, 32'd7, 5'd3);
    // only MEM/WB writes
    tbl[2] = mk_vec(mk_id(1, 2, 3, 5, 7, 0, 0, 0, 1, ALU_ADD, 1, 0, 0),
                    0, 1, 32'h10, 1, 1, 32'h20, 32'h20, 32'd7, 32'd7, 5'd3);
    // $0 never forwarded
    tbl[3] = mk_vec(mk_id(0, 2, 3, 32'h55, 7, 0, 0, 0, 1, ALU_ADD, 1, 0, 0),
                    1, 0, 32'h10, 1, 0, 32'h20, 32'h55, 32'd7, 32'd7, 5'd3);
    // addi $2,$1,-1
    tbl[4] = mk_vec(mk_id(1, 2, 0, 5, 9, 16'hFFFF, 0, 1, 0, ALU_ADD, 1, 0, 0),
                    0, 0, 0, 0, 0, 0, 32'd5, 32'hFFFF_FFFF, 32'd9, 5'd2);
    // andi $2,$1,0xFFFF
    tbl[5] = mk_vec(mk_id(1, 2, 0, 5, 9, 16'hFFFF, 1, 1, 0, ALU_AND, 1, 0, 0),
                    0, 0, 0, 0, 0, 0, 32'd5, 32'h0000_FFFF, 32'd9, 5'd2);
    // sw $2,4($1): store data forwarded, operand 2 is the immediate
    tbl[6] = mk_vec(mk_id(1, 2, 0, 5, 9, 16'h0004, 0, 1, 0, ALU_LSW, 0, 0, 1),
                    0, 0, 0, 1, 2, 32'h77, 32'd5, 32'd4, 32'h77, 5'd2);
    // rt forwarded from EX/MEM over MEM/WB
    tbl[7] = mk_vec(mk_id(3, 4, 6, 32'h33, 32'h44, 0, 0, 0, 1, ALU_SLT, 1, 0, 0),
                    1, 4, 32'hAB, 1, 4, 32'hCD, 32'h33, 32'hAB, 32'hAB, 5'd6);

    rst_n = 1'b0; cur = '0; flush = 1'b0; m_ex = '0;
    set_fwd(0, 0, 0, 0, 0, 0);
    #12;
    chk_all_zero("rst0");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cur = tbl[i].id;
      set_fwd(tbl[i].ew, tbl[i].erd, tbl[i].eres, tbl[i].mw, tbl[i].mrd, tbl[i].mres);
      cycle();
      chk($sformatf("tbl%0d_valid", i), 32'(ex_valid), 1);
      chk($sformatf("tbl%0d_in1", i), alu_in1, tbl[i].e_in1);
      chk($sformatf("tbl%0d_in2", i), alu_in2, tbl[i].e_in2);
      chk($sformatf("tbl%0d_store", i), ex_store_data, tbl[i].e_st);
      chk($sformatf("tbl%0d_dest", i), 32'(ex_dest), 32'(tbl[i].e_dest));
      chk($sformatf("tbl%0d_ctrl", i), 32'(alu_ctrl), 32'(tbl[i].id.ctrl));
    end

    // lw $4 then add $5,$4,$4
    set_fwd(0, 0, 0, 0, 0, 0);
    cur = mk_id(1, 4, 0, 32'h100, 0, 16'h0008, 0, 1, 0, ALU_LSW, 1, 1, 0);
    cycle();
    cur = mk_id(4, 4, 5, 32'hAAAA, 32'hAAAA, 0, 0, 0, 1, ALU_ADD, 1, 0, 0);
    #1 chk("lu_stall", 32'(load_use_stall), 1);
    cycle();
    chk("lu_bub_valid", 32'(ex_valid), 0);
    chk("lu_bub_regw", 32'(ex_reg_write), 0);
    chk("lu_bub_mr", 32'(ex_mem_read), 0);
    chk("lu_bub_ctrl", 32'(alu_ctrl), 0);
    chk("lu_stall_once", 32'(load_use_stall), 0);
    set_fwd(0, 0, 0, 1, 4, 32'h1234);
    cycle();
    chk("lu_issue_valid", 32'(ex_valid), 1);
    chk("lu_issue_in1", alu_in1, 32'h1234);
    chk("lu_issue_in2", alu_in2, 32'h1234);

    // flush coinciding with a load-use stall
    set_fwd(0, 0, 0, 0, 0, 0);
    cur = mk_id(1, 4, 0, 32'h100, 0, 16'h0008, 0, 1, 0, ALU_LSW, 1, 1, 0);
    cycle();
    cur = mk_id(4, 4, 5, 32'hAAAA, 32'hAAAA, 0, 0, 0, 1, ALU_ADD, 1, 0, 0);
    flush = 1'b1;
    #1 chk("fl_stall", 32'(load_use_stall), 1);
    cycle();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_regw", 32'(ex_reg_write), 0);
    chk("fl_mw", 32'(ex_mem_write), 0);
    // flush of a store
    cur = mk_id(1, 2, 0, 5, 9, 16'h0004, 0, 1, 0, ALU_LSW, 0, 0, 1);
    cycle();
    chk("fl_sw_valid", 32'(ex_valid), 0);
    chk("fl_sw_mw", 32'(ex_mem_write), 0);
    flush = 1'b0;

    // reset in the middle of traffic
    cur = mk_id(1, 2, 3, 5, 7, 0, 0, 0, 1, ALU_NOR, 1, 0, 0);
    cycle();
    chk("pre_rst_valid", 32'(ex_valid), 1);
    #2 rst_n = 1'b0;
    m_ex = '0;
    #1 chk_all_zero("rst_mid");
    @(posedge clk);
    #1 chk("rst_hold_valid", 32'(ex_valid), 0);
    rst_n = 1'b1;
    cur.valid = 1'b0;
    cycle();
    chk("rst_idle_valid", 32'(ex_valid), 0);
    cur.valid = 1'b1;
    cycle();
    chk("rst_first_valid", 32'(ex_valid), 1);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      cur.valid   = ($urandom_range(0, 3) != 0);
      cur.rs      = 5'($urandom_range(0, 3));
      cur.rt      = 5'($urandom_range(0, 3));
      cur.rd      = 5'($urandom_range(0, 3));
      cur.rsd     = $urandom;
      cur.rtd     = $urandom;
      cur.imm     = 16'($urandom);
      cur.zext    = 1'($urandom);
      cur.alu_src = 1'($urandom);
      cur.reg_dst = 1'($urandom);
      cur.ctrl    = 4'($urandom);
      cur.regw    = 1'($urandom);
      cur.mr      = ($urandom_range(0, 2) == 0);
      cur.mw      = 1'($urandom);
      flush       = ($urandom_range(0, 7) == 0);
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-delivery stage of the pipelined MIPS core, sitting directly upstream of the ALU. It captures decoded instruction fields and register-file read data each cycle and resolves EX/MEM and MEM/WB forwarding. It selects and extends the immediate and drives the ALU's two 32-bit operands and its 4-bit control code. It also detects load-use hazards and inserts bubbles on load-use stall or branch flush.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_AW each  source/destination register numbers
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data
- id_imm16  in  16  instruction immediate field
- id_zero_ext  in  1  1 = zero-extend immediate (andi), 0 = sign-extend
- id_alu_src  in  1  1 = ALU operand 2 is the immediate
- id_reg_dst  in  1  1 = destination is rd, 0 = rt
- id_alu_ctrl  in  4  ALU control code
- id_reg_write, id_mem_read, id_mem_write  in  1 each  decoded control
- flush  in  1  branch/jump taken; kill the instruction entering EX
- exmem_reg_write  in  1  EX/MEM instruction writes a register
- exmem_rd  in  REG_AW  EX/MEM destination register
- exmem_result  in  DATA_W  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB instruction writes a register
- memwb_rd  in  REG_AW  MEM/WB destination register
- memwb_result  in  DATA_W  MEM/WB write-back value
- alu_in1, alu_in2  out  DATA_W each  ALU operands
- alu_ctrl  out  4  ALU control code
- ex_valid  out  1  EX holds a real instruction
- ex_store_data  out  DATA_W  forwarded rt value for sw
- ex_dest  out  REG_AW  write-back register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control passed to EX/MEM
- load_use_stall  out  1  to PC/IF/ID: hold fetch and decode this cycle

## Operation
- Capture per edge, priority: reset > flush > load_use_stall > normal capture.
- Flush or load_use_stall: load a bubble. A bubble clears all control bits and sets valid=0, ctrl=4'b0000, dest=0, and all data and address fields to 0.
- Normal capture: latch every id_* field. valid = id_valid. dest = id_reg_dst ? id_rd_addr : id_rt_addr.
- Immediate: extended to 32 bits at capture and stored extended. Sign-extension replicates bit 15; zero-extension fills with zeros.
- Forwarding, per operand, using registered rs and rt addresses:
  - EX/MEM is selected if exmem_reg_write is 1, exmem_rd matches, and the address is nonzero.
  - Otherwise MEM/WB is selected if memwb_reg_write is 1, memwb_rd matches, and the address is nonzero.
  - Otherwise the registered read data is used.
  - Register 0 is never forwarded. EX/MEM wins over MEM/WB when both match.
- alu_in1 = forwarded rs. alu_in2 = alu_src ? extended immediate : forwarded rt.
- ex_store_data = forwarded rt, regardless of alu_src.
- load_use_stall = ex_valid & ex_mem_read & id_valid & (ex_dest != 0) & (ex_dest == id_rs_addr | ex_dest == id_rt_addr).
  - Rt is compared even for immediate-form instructions; the stall is conservative by design.
- flush and stall in the same cycle: one bubble. The flush kills the instruction held in ID.
- Register-file write-then-read in the same cycle is the register file's responsibility, not this block's.

## Timing
- Reset (async assert, sync release) values:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall = 0.
  - ex_dest = 0, alu_ctrl = 4'b0000.
  - alu_in1, alu_in2, ex_store_data = 0.
- Register latency: one cycle from id_* inputs to the registered outputs.
- alu_in1, alu_in2, ex_store_data: combinational from the stage registers and the current exmem_*/memwb_* inputs, in the same cycle.
- load_use_stall: combinational in the cycle the dependent instruction is in ID. The next edge loads a bubble, and ID/IF must hold. The dependent instruction enters EX one cycle late and takes its operand from MEM/WB.
- Reset mid-operation: all in-flight state is discarded immediately; no partial outputs.

## Structure
- Shared package mips_pkg:
  - ALU control constants ALU_ADD 4'b0000, ALU_LSW 4'b0010, ALU_SLL 4'b0100, ALU_AND 4'b0101, ALU_NOR 4'b0111, ALU_BEQ 4'b1000, ALU_SLT 4'b1011.
  - Forward-select enum FWD_REG, FWD_EXMEM, FWD_MEMWB.
  - DATA_W and REG_AW defaults.
- Sub-module fwd_mux, instantiated once for rs and once for rt. It computes the 2-bit select (priority plus register-0 exclusion) and outputs the 32-bit operand.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately. ex_valid remains 0 until the first captured id_valid=1 after release.
- add $3,$1,$2 with rs_data=5, rt_data=7, no forwarding -> next cycle alu_in1=5, alu_in2=7, alu_ctrl=0000, ex_dest=3.
- Dependent pair: exmem_rd=1 with result 0x10 and memwb_rd=1 with result 0x20 both writing -> alu_in1=0x10. With exmem_reg_write=0 -> alu_in1=0x20. With rs=0 and both writing rd=0 -> alu_in1 = registered data.
- addi with imm16=0xFFFF -> alu_in2=0xFFFFFFFF. andi with 0xFFFF -> alu_in2=0x0000FFFF. sw -> ex_store_data = forwarded rt while alu_in2 = immediate.
- lw $4 in EX followed by add $5,$4,$4 in ID -> load_use_stall=1 for exactly one cycle. The next cycle has ex_valid=0 with all control 0. The add then issues with alu_in1 = memwb_result.
- flush=1 with id_valid=1 (including simultaneous with load_use_stall) -> next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0.
